regfile_2r1w_sweep: RTL

//  Parametrised 2-read/1-write register file for the datapath operand store.

---
 rtl/regfile_2r1w_sweep.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_2r1w_sweep.sv
// Two-read / one-write register file with registered reads, write-first bypass,
// an optional hardwired-zero entry 0 and a sequential clear-sweep engine.
module regfile_2r1w_sweep #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r_add1,
  input  logic [ADDR_W-1:0] r_add2,
  input  logic [ADDR_W-1:0] w_add,
  input  logic              w_flag,
  input  logic [DATA_W-1:0] w_data,
  input  logic              clr_req,
  output logic              busy,
  output logic [DATA_W-1:0] r_data1,
  output logic [DATA_W-1:0] r_data2
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   r_data1_q, r_data2_q;

  logic                wr_ok;
  logic [DATA_W-1:0]   r_data1_d, r_data2_d;

  // Writes are blocked during a sweep, so the bypass path only matters in IDLE.
  always_comb begin
    wr_ok = w_flag && !busy_q && !(ZERO_REG && (w_add == '0));

    if (ZERO_REG && (r_add1 == '0))          r_data1_d = '0;
    else if (wr_ok && (w_add == r_add1))     r_data1_d = w_data;
    else                                     r_data1_d = mem_q[r_add1];

    if (ZERO_REG && (r_add2 == '0))          r_data2_d = '0;
    else if (wr_ok && (w_add == r_add2))     r_data2_d = w_data;
    else                                     r_data2_d = mem_q[r_add2];
  end

  // NOTE: the storage array is reset explicitly because reset must leave every
  // entry reading zero; this forces flops rather than a RAM macro, which is
  // acceptable at this depth. All state here uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      r_data1_q <= '0;
      r_data2_q <= '0;
      busy_q    <= 1'b0;
      state_q   <= IDLE;
      ptr_q     <= '0;
    end else begin
      if (wr_ok) mem_q[w_add] <= w_data;
      r_data1_q <= r_data1_d;
      r_data2_q <= r_data2_d;

      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
        CLEAR: begin
          mem_q[ptr_q] <= '0;
          ptr_q        <= ptr_q + 1'b1;
          // Last entry cleared this edge; ptr wraps back to 0 on its own.
          if (ptr_q == {ADDR_W{1'b1}}) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign r_data1 = r_data1_q;
  assign r_data2 = r_data2_q;

endmodule
